// File: rtl/aud_transport_if.sv
// Control-side signal bundle between the transport controller and the
// surrounding codec/DSP/keypad logic.
interface aud_transport_if #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned SPD_W  = 4,
    parameter int unsigned TIME_W = 8
);
    logic              i_init_fin;
    logic              i_mode;
    logic              i_loop;
    logic              i_key_start;
    logic              i_key_stop;
    logic              i_key_up;
    logic              i_key_down;
    logic [ADDR_W-1:0] i_addr;
    logic              o_init_start;
    logic [1:0]        o_ctrl;
    logic              o_mode;
    logic [SPD_W-1:0]  o_speed;
    logic [ADDR_W-1:0] o_rec_end;
    logic              o_rec_valid;
    logic [TIME_W-1:0] o_time_sec;
    logic [2:0]        o_state;

    // System side: drives keys, switches and the DSP address
    modport master (
        output i_init_fin, i_mode, i_loop, i_key_start, i_key_stop,
               i_key_up, i_key_down, i_addr,
        input  o_init_start, o_ctrl, o_mode, o_speed, o_rec_end,
               o_rec_valid, o_time_sec, o_state
    );

    // Controller side
    modport slave (
        input  i_init_fin, i_mode, i_loop, i_key_start, i_key_stop,
               i_key_up, i_key_down, i_addr,
        output o_init_start, o_ctrl, o_mode, o_speed, o_rec_end,
               o_rec_valid, o_time_sec, o_state
    );
endinterface

// File: rtl/aud_transport_ctrl.sv
// Record/playback transport controller for the WM8731 audio path:
// codec init sequencing, DSP control/speed/mode, recording end tracking
// and an elapsed-seconds counter.
module aud_transport_ctrl #(
    parameter int unsigned ADDR_W   = 20,
    parameter int unsigned SPD_W    = 4,
    parameter int unsigned SPD_MAX  = 14,
    parameter int unsigned SPD_NORM = 7,
    parameter int unsigned CLK_HZ   = 12000000,
    parameter int unsigned TIME_W   = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    aud_transport_if.slave  bus
);

    localparam int unsigned SUB_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    localparam logic [2:0] ST_INIT   = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_PAUSE  = 3'd3;
    localparam logic [2:0] ST_RELOAD = 3'd4;

    localparam logic [1:0] CTRL_NONE  = 2'd0;
    localparam logic [1:0] CTRL_RESET = 2'd1;
    localparam logic [1:0] CTRL_INC   = 2'd2;
    localparam logic [1:0] CTRL_PAUSE = 2'd3;

    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(CLK_HZ - 1);
    localparam logic [TIME_W-1:0] TIME_LAST = {TIME_W{1'b1}};
    localparam logic [SPD_W-1:0]  SPD_TOP   = SPD_W'(SPD_MAX);
    localparam logic [SPD_W-1:0]  SPD_MID   = SPD_W'(SPD_NORM);

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic              rec_load_c;
    logic              time_clr_c;

    logic              init_issued;
    logic              init_start_r;
    logic [1:0]        ctrl_r;
    logic              mode_r;
    logic [SPD_W-1:0]  speed_r;
    logic [ADDR_W-1:0] rec_end_r;
    logic              rec_valid_r;
    logic [SUB_W-1:0]  sub_r;
    logic [TIME_W-1:0] time_r;

    function automatic logic [1:0] ctrl_of(input logic [2:0] st);
        case (st)
            ST_IDLE:   ctrl_of = CTRL_RESET;
            ST_RUN:    ctrl_of = CTRL_INC;
            ST_PAUSE:  ctrl_of = CTRL_PAUSE;
            ST_RELOAD: ctrl_of = CTRL_RESET;
            default:   ctrl_of = CTRL_NONE;
        endcase
    endfunction

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_INIT;
        else          state <= state_next;
    end

    // Next-state logic; stop/end conditions take priority over start
    always_comb begin
        state_next = state;
        rec_load_c = 1'b0;
        time_clr_c = 1'b0;
        case (state)
            ST_INIT: begin
                if (bus.i_init_fin) state_next = ST_IDLE;
            end
            ST_IDLE: begin
                // Playback needs an existing recording; mode is taken live here
                if (bus.i_key_start && (bus.i_mode || rec_valid_r)) begin
                    state_next = ST_RUN;
                    time_clr_c = 1'b1;
                end
            end
            ST_RUN: begin
                if (mode_r) begin
                    if (bus.i_key_stop || (bus.i_addr == ADDR_LAST)) begin
                        state_next = ST_IDLE;
                        rec_load_c = 1'b1;
                    end else if (bus.i_key_start) begin
                        state_next = ST_PAUSE;
                    end
                end else begin
                    if (bus.i_key_stop) begin
                        state_next = ST_IDLE;
                    end else if (bus.i_addr >= rec_end_r) begin
                        state_next = bus.i_loop ? ST_RELOAD : ST_IDLE;
                    end else if (bus.i_key_start) begin
                        state_next = ST_PAUSE;
                    end
                end
            end
            ST_PAUSE: begin
                if (bus.i_key_stop) begin
                    state_next = ST_IDLE;
                    rec_load_c = mode_r;
                end else if (bus.i_key_start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RELOAD: begin
                state_next = ST_RUN;
                time_clr_c = 1'b1;
            end
            default: state_next = ST_INIT;
        endcase
    end

    // Init request pulse on the first cycle after reset, and DSP control code
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            init_issued  <= 1'b0;
            init_start_r <= 1'b0;
            ctrl_r       <= CTRL_NONE;
        end else begin
            init_issued  <= 1'b1;
            init_start_r <= !init_issued;
            ctrl_r       <= ctrl_of(state_next);
        end
    end

    // Mode follows the switch only while idle; recording end capture
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_r      <= 1'b1;
            rec_end_r   <= '0;
            rec_valid_r <= 1'b0;
        end else begin
            if (state == ST_IDLE) mode_r <= bus.i_mode;
            if (rec_load_c) begin
                rec_end_r   <= bus.i_addr;
                rec_valid_r <= 1'b1;
            end
        end
    end

    // Playback speed: saturating up/down, pinned to normal in record mode
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            speed_r <= SPD_MID;
        end else if (mode_r) begin
            speed_r <= SPD_MID;
        end else if (bus.i_key_up && !bus.i_key_down && (speed_r != SPD_TOP)) begin
            speed_r <= speed_r + SPD_W'(1);
        end else if (bus.i_key_down && !bus.i_key_up && (speed_r != '0)) begin
            speed_r <= speed_r - SPD_W'(1);
        end
    end

    // Elapsed time: sub-second prescaler runs only in RUN, seconds saturate
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sub_r  <= '0;
            time_r <= '0;
        end else if (time_clr_c) begin
            sub_r  <= '0;
            time_r <= '0;
        end else if (state == ST_RUN) begin
            if (sub_r == SUB_LAST) begin
                sub_r <= '0;
                if (time_r != TIME_LAST) time_r <= time_r + TIME_W'(1);
            end else begin
                sub_r <= sub_r + SUB_W'(1);
            end
        end
    end

    assign bus.o_init_start = init_start_r;
    assign bus.o_ctrl       = ctrl_r;
    assign bus.o_mode       = mode_r;
    assign bus.o_speed      = speed_r;
    assign bus.o_rec_end    = rec_end_r;
    assign bus.o_rec_valid  = rec_valid_r;
    assign bus.o_time_sec   = time_r;
    assign bus.o_state      = state;

endmodule

// File: tb/tb_aud_transport_ctrl.sv
// Directed bench for aud_transport_ctrl with CLK_HZ = 10, ADDR_W = 8.
module tb_aud_transport_ctrl;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned SPD_W  = 4;
    localparam int unsigned TIME_W = 8;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    aud_transport_if #(.ADDR_W(ADDR_W), .SPD_W(SPD_W), .TIME_W(TIME_W)) bus ();

    aud_transport_ctrl #(
        .ADDR_W(ADDR_W), .SPD_W(SPD_W), .SPD_MAX(14), .SPD_NORM(7),
        .CLK_HZ(10), .TIME_W(TIME_W)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: active edge, then land on the falling edge for sampling/driving
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic press(input logic st, input logic sp, input logic up, input logic dn);
        bus.i_key_start = st;
        bus.i_key_stop  = sp;
        bus.i_key_up    = up;
        bus.i_key_down  = dn;
        tick();
        bus.i_key_start = 1'b0;
        bus.i_key_stop  = 1'b0;
        bus.i_key_up    = 1'b0;
        bus.i_key_down  = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n           = 1'b0;
        bus.i_init_fin  = 1'b0;
        bus.i_mode      = 1'b1;
        bus.i_loop      = 1'b0;
        bus.i_key_start = 1'b0;
        bus.i_key_stop  = 1'b0;
        bus.i_key_up    = 1'b0;
        bus.i_key_down  = 1'b0;
        bus.i_addr      = '0;
        tick(3);

        // Reset values
        chk("rst_state", 32'(bus.o_state), 32'd0);
        chk("rst_ctrl", 32'(bus.o_ctrl), 32'd0);
        chk("rst_init_start", 32'(bus.o_init_start), 32'd0);
        chk("rst_mode", 32'(bus.o_mode), 32'd1);
        chk("rst_speed", 32'(bus.o_speed), 32'd7);
        chk("rst_rec_end", 32'(bus.o_rec_end), 32'd0);
        chk("rst_rec_valid", 32'(bus.o_rec_valid), 32'd0);
        chk("rst_time", 32'(bus.o_time_sec), 32'd0);

        // Init sequencing: pulse in cycle 1 only, IDLE one cycle after fin
        rst_n = 1'b1;
        tick();
        chk("init_pulse_c1", 32'(bus.o_init_start), 32'd1);
        chk("init_ctrl_c1", 32'(bus.o_ctrl), 32'd0);
        tick();
        chk("init_pulse_c2", 32'(bus.o_init_start), 32'd0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        chk("init_key_ignored", 32'(bus.o_state), 32'd0);
        tick();
        bus.i_init_fin = 1'b1;
        chk("init_ctrl_c4", 32'(bus.o_ctrl), 32'd0);
        tick();
        chk("init_ctrl_idle", 32'(bus.o_ctrl), 32'd1);
        chk("init_state_idle", 32'(bus.o_state), 32'd1);

        // Record take: 26 RUN cycles -> 2 seconds, end captured at 0x40
        press(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rec_ctrl_run", 32'(bus.o_ctrl), 32'd2);
        chk("rec_time_clr", 32'(bus.o_time_sec), 32'd0);
        tick(24);
        bus.i_addr = 8'h40;
        tick();
        chk("rec_time_25", 32'(bus.o_time_sec), 32'd2);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        chk("rec_stop_ctrl", 32'(bus.o_ctrl), 32'd1);
        chk("rec_end", 32'(bus.o_rec_end), 32'h40);
        chk("rec_valid", 32'(bus.o_rec_valid), 32'd1);
        chk("rec_time_held", 32'(bus.o_time_sec), 32'd2);

        // Play, no loop: stops when address reaches the recording end
        bus.i_mode = 1'b0;
        bus.i_addr = '0;
        tick(2);
        chk("play_mode", 32'(bus.o_mode), 32'd0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        chk("play_ctrl_run", 32'(bus.o_ctrl), 32'd2);
        for (int a = 16; a < 64; a++) begin
            bus.i_addr = 8'(a);
            tick();
        end
        chk("play_before_end", 32'(bus.o_ctrl), 32'd2);
        bus.i_addr = 8'h40;
        tick();
        chk("play_end_ctrl", 32'(bus.o_ctrl), 32'd1);
        chk("play_end_state", 32'(bus.o_state), 32'd1);

        // Play with loop: one RELOAD cycle, time cleared
        bus.i_loop = 1'b1;
        bus.i_addr = '0;
        press(1'b1, 1'b0, 1'b0, 1'b0);
        tick(15);
        chk("loop_time_1", 32'(bus.o_time_sec), 32'd1);
        bus.i_addr = 8'h40;
        tick();
        chk("loop_reload_ctrl", 32'(bus.o_ctrl), 32'd1);
        chk("loop_reload_state", 32'(bus.o_state), 32'd4);
        bus.i_addr = '0;
        tick();
        chk("loop_run_ctrl", 32'(bus.o_ctrl), 32'd2);
        chk("loop_time_clr", 32'(bus.o_time_sec), 32'd0);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        chk("loop_stop_state", 32'(bus.o_state), 32'd1);
        bus.i_loop = 1'b0;

        // Speed in play mode
        for (int i = 0; i < 8; i++) press(1'b0, 1'b0, 1'b1, 1'b0);
        chk("spd_sat_max", 32'(bus.o_speed), 32'd14);
        press(1'b0, 1'b0, 1'b1, 1'b1);
        chk("spd_up_down", 32'(bus.o_speed), 32'd14);
        press(1'b0, 1'b0, 1'b0, 1'b1);
        chk("spd_down", 32'(bus.o_speed), 32'd13);
        bus.i_mode = 1'b1;
        tick(2);
        chk("spd_record_norm", 32'(bus.o_speed), 32'd7);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        chk("spd_record_key", 32'(bus.o_speed), 32'd7);

        // Reset mid-operation forgets the recording and re-inits
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", 32'(bus.o_state), 32'd0);
        chk("mid_rst_valid", 32'(bus.o_rec_valid), 32'd0);
        chk("mid_rst_end", 32'(bus.o_rec_end), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_rst_pulse", 32'(bus.o_init_start), 32'd1);
        tick();
        chk("mid_rst_pulse_off", 32'(bus.o_init_start), 32'd0);

        // Play without a recording is ignored
        bus.i_mode = 1'b0;
        tick(2);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        chk("play_no_rec", 32'(bus.o_state), 32'd1);

        // Record auto-stop at last address
        bus.i_mode = 1'b1;
        tick(2);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        bus.i_addr = 8'hFE;
        tick();
        chk("auto_before", 32'(bus.o_state), 32'd2);
        bus.i_addr = 8'hFF;
        tick();
        chk("auto_stop_state", 32'(bus.o_state), 32'd1);
        chk("auto_stop_end", 32'(bus.o_rec_end), 32'hFF);
        chk("auto_stop_valid", 32'(bus.o_rec_valid), 32'd1);

        // Start and stop together in RUN: stop wins
        bus.i_addr = '0;
        press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b1, 1'b0, 1'b0);
        chk("both_keys_state", 32'(bus.o_state), 32'd1);
        chk("both_keys_end", 32'(bus.o_rec_end), 32'd0);

        // Pause holds time and mode
        press(1'b1, 1'b0, 1'b0, 1'b0);
        tick(12);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        chk("pause_ctrl", 32'(bus.o_ctrl), 32'd3);
        chk("pause_time", 32'(bus.o_time_sec), 32'd1);
        tick(20);
        chk("pause_time_held", 32'(bus.o_time_sec), 32'd1);
        bus.i_mode = 1'b0;
        tick(2);
        chk("pause_mode_frozen", 32'(bus.o_mode), 32'd1);
        bus.i_addr = 8'h22;
        press(1'b0, 1'b1, 1'b0, 1'b0);
        chk("pause_stop_state", 32'(bus.o_state), 32'd1);
        chk("pause_stop_end", 32'(bus.o_rec_end), 32'h22);
        tick();
        chk("idle_mode_tracks", 32'(bus.o_mode), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
